// File: rtl/gin_pkg.sv
// Shared definitions for the GIN packet sequencer.
// Contents:
//   - state_t          : sequencer FSM states
//   - PE_RESET_ACTIVE  : level that clears the PE accumulators (active-low)
//   - LOAD_ADDR_W      : host load address width
//   - pkt_width()      : packet width {row_tag, col_tag, data}
//   - diag_len()       : ifmap diagonal length / ifmap packets per pass
//   - cnt_width()      : counter width for a modulo-n counter (minimum 1 bit)
package gin_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_GAP    = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic        PE_RESET_ACTIVE = 1'b0;
  localparam int unsigned LOAD_ADDR_W     = 8;

  function automatic int unsigned pkt_width(input int unsigned bitwidth,
                                            input int unsigned tag_length);
    return 2 * tag_length + bitwidth;
  endfunction

  function automatic int unsigned diag_len(input int unsigned pe_y,
                                           input int unsigned pe_x);
    return pe_y + pe_x - 1;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gin_tile_buffer.sv
// Operand tile buffer: one synchronous write port, one asynchronous read port.
// Writes and reads with an address >= DEPTH are ignored / return 0.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (clears all entries)
//   we        : write enable
//   waddr     : write address (AW bits)
//   wdata     : write data (WIDTH bits)
//   raddr     : read address (AW bits)
//   rdata     : read data, combinational
module gin_tile_buffer
  import gin_pkg::*;
#(
  parameter int unsigned DEPTH = 9,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned IDX_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_wr_hit;
  logic             w_rd_hit;

  assign w_wr_hit = we && (waddr < AW'(DEPTH));
  assign w_rd_hit = (raddr < AW'(DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_hit) begin
      r_mem[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  assign rdata = w_rd_hit ? r_mem[raddr[IDX_W-1:0]] : '0;

endmodule

// File: rtl/gin_packet_sequencer.sv
// Upstream feeder for ml_accelerator: holds one filter tile and one ifmap
// diagonal tile written by the host and replays them as tagged GIN packets
// {row_tag, col_tag, data}, with the PE clear / enable / ofmap timing.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   load_en/sel/addr/data: host write (sel 0 = filter, 1 = ifmap), only when load_ready
//   load_ready          : 1 when idle
//   start               : one-cycle job request, ignored unless idle
//   busy                : 1 while a job runs
//   data_packet_ifmap   : {0, d, ifmap[d][p]}
//   data_packet_filter  : {0, p, filter[r][p]}
//   gin_enable_ifmap/filter : packet valids
//   pe_reset            : active-low PE accumulator clear
//   ofmap_valid         : one-cycle strobe, ofmap row is final
module gin_packet_sequencer
  import gin_pkg::*;
#(
  parameter int unsigned BITWIDTH     = 16,
  parameter int unsigned TAG_LENGTH   = 4,
  parameter int unsigned PE_Y_SIZE    = 3,
  parameter int unsigned PE_X_SIZE    = 3,
  parameter int unsigned FILT_W       = 3,
  parameter int unsigned DRAIN_CYCLES = 5
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load_en,
  input  logic                                        load_sel,
  input  logic [LOAD_ADDR_W-1:0]                      load_addr,
  input  logic [BITWIDTH-1:0]                         load_data,
  output logic                                        load_ready,
  input  logic                                        start,
  output logic                                        busy,
  output logic [pkt_width(BITWIDTH, TAG_LENGTH)-1:0]  data_packet_ifmap,
  output logic [pkt_width(BITWIDTH, TAG_LENGTH)-1:0]  data_packet_filter,
  output logic                                        gin_enable_ifmap,
  output logic                                        gin_enable_filter,
  output logic                                        pe_reset,
  output logic                                        ofmap_valid
);

  localparam int unsigned DIAG = diag_len(PE_Y_SIZE, PE_X_SIZE);
  localparam int unsigned PKT  = pkt_width(BITWIDTH, TAG_LENGTH);
  localparam int unsigned KW   = cnt_width(DIAG);
  localparam int unsigned PW   = cnt_width(FILT_W);
  localparam int unsigned DW   = cnt_width(DRAIN_CYCLES);
  localparam logic [TAG_LENGTH-1:0] ROW_TAG = '0;

  state_t                  r_state;
  logic [KW-1:0]           r_k;
  logic [PW-1:0]           r_p;
  logic [DW-1:0]           r_dcnt;
  logic                    r_load_ready;
  logic                    r_busy;
  logic                    r_pe_reset;
  logic                    r_en_ifmap;
  logic                    r_en_filter;
  logic [PKT-1:0]          r_pkt_ifmap;
  logic [PKT-1:0]          r_pkt_filter;
  logic                    r_ofmap_valid;

  logic                    w_load_we;
  logic [LOAD_ADDR_W-1:0]  w_rd_addr;
  logic [BITWIDTH-1:0]     w_ifmap_data;
  logic [BITWIDTH-1:0]     w_filter_data;
  logic                    w_filter_en;
  logic                    w_k_last;
  logic                    w_p_last;
  logic                    w_stream_done;

  assign w_load_we = load_en && r_load_ready;

  // Both tiles share the {row|diag}*FILT_W + pass address layout.
  assign w_rd_addr = LOAD_ADDR_W'(r_k) * LOAD_ADDR_W'(FILT_W) + LOAD_ADDR_W'(r_p);

  gin_tile_buffer #(
    .DEPTH (PE_Y_SIZE * FILT_W),
    .WIDTH (BITWIDTH),
    .AW    (LOAD_ADDR_W)
  ) u_filter_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (w_load_we && !load_sel),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (w_rd_addr),
    .rdata (w_filter_data)
  );

  gin_tile_buffer #(
    .DEPTH (DIAG * FILT_W),
    .WIDTH (BITWIDTH),
    .AW    (LOAD_ADDR_W)
  ) u_ifmap_buf (
    .clk   (clk),
    .rst   (rst),
    .we    (w_load_we && load_sel),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (w_rd_addr),
    .rdata (w_ifmap_data)
  );

  assign w_filter_en = (32'(r_k) < PE_Y_SIZE);
  assign w_k_last    = (r_k == KW'(DIAG - 1));
  assign w_p_last    = (r_p == PW'(FILT_W - 1));
  // r_k/r_p point at the next beat to emit; back at (0,0) inside STREAM means
  // the last beat of the last pass is already on the outputs.
  assign w_stream_done = (r_state == ST_STREAM) && (r_k == '0) && (r_p == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_k           <= '0;
      r_p           <= '0;
      r_dcnt        <= '0;
      r_load_ready  <= 1'b1;
      r_busy        <= 1'b0;
      r_pe_reset    <= ~PE_RESET_ACTIVE;
      r_en_ifmap    <= 1'b0;
      r_en_filter   <= 1'b0;
      r_pkt_ifmap   <= '0;
      r_pkt_filter  <= '0;
      r_ofmap_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_CLEAR;
            r_busy       <= 1'b1;
            r_load_ready <= 1'b0;
            r_pe_reset   <= PE_RESET_ACTIVE;
            r_k          <= '0;
            r_p          <= '0;
          end
        end
        ST_CLEAR: begin
          r_state    <= ST_GAP;
          r_pe_reset <= ~PE_RESET_ACTIVE;
        end
        ST_GAP, ST_STREAM: begin
          if (w_stream_done) begin
            r_state      <= ST_DRAIN;
            r_en_ifmap   <= 1'b0;
            r_en_filter  <= 1'b0;
            r_pkt_ifmap  <= '0;
            r_pkt_filter <= '0;
            r_dcnt       <= '0;
          end else begin
            r_state      <= ST_STREAM;
            r_en_ifmap   <= 1'b1;
            r_pkt_ifmap  <= {ROW_TAG, TAG_LENGTH'(r_k), w_ifmap_data};
            r_en_filter  <= w_filter_en;
            r_pkt_filter <= w_filter_en ? {ROW_TAG, TAG_LENGTH'(r_p), w_filter_data} : '0;
            if (w_k_last) begin
              r_k <= '0;
              r_p <= w_p_last ? '0 : r_p + PW'(1);
            end else begin
              r_k <= r_k + KW'(1);
            end
          end
        end
        ST_DRAIN: begin
          if (r_dcnt == DW'(DRAIN_CYCLES - 1)) begin
            r_state       <= ST_DONE;
            r_ofmap_valid <= 1'b1;
          end else begin
            r_dcnt <= r_dcnt + DW'(1);
          end
        end
        ST_DONE: begin
          r_state       <= ST_IDLE;
          r_ofmap_valid <= 1'b0;
          r_busy        <= 1'b0;
          r_load_ready  <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready         = r_load_ready;
  assign busy               = r_busy;
  assign pe_reset           = r_pe_reset;
  assign gin_enable_ifmap   = r_en_ifmap;
  assign gin_enable_filter  = r_en_filter;
  assign data_packet_ifmap  = r_pkt_ifmap;
  assign data_packet_filter = r_pkt_filter;
  assign ofmap_valid        = r_ofmap_valid;

endmodule

// File: tb/tb_gin_packet_sequencer.sv
// Scoreboard bench for gin_packet_sequencer. The reference model keeps the
// tiles as 2-D arrays, queues the expected packets when a job is accepted,
// and derives the control timing arithmetically from the accepted start edge.
module tb_gin_packet_sequencer;

  localparam int BW   = 16;
  localparam int TL   = 4;
  localparam int PY   = 3;
  localparam int PX   = 3;
  localparam int FW   = 3;
  localparam int DR   = 5;
  localparam int DIAG = PY + PX - 1;
  localparam int PKT  = 2 * TL + BW;
  // Offsets (in cycles after the edge that samples start) of each phase.
  localparam int FIRST    = 2;
  localparam int LAST     = FIRST + FW * DIAG - 1;
  localparam int DONE_OFS = LAST + DR + 1;
  localparam int NEXT_OK  = DONE_OFS + 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_en;
  logic           load_sel;
  logic [7:0]     load_addr;
  logic [BW-1:0]  load_data;
  logic           load_ready;
  logic           start;
  logic           busy;
  logic [PKT-1:0] data_packet_ifmap;
  logic [PKT-1:0] data_packet_filter;
  logic           gin_enable_ifmap;
  logic           gin_enable_filter;
  logic           pe_reset;
  logic           ofmap_valid;

  gin_packet_sequencer #(
    .BITWIDTH     (BW),
    .TAG_LENGTH   (TL),
    .PE_Y_SIZE    (PY),
    .PE_X_SIZE    (PX),
    .FILT_W       (FW),
    .DRAIN_CYCLES (DR)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .load_en            (load_en),
    .load_sel           (load_sel),
    .load_addr          (load_addr),
    .load_data          (load_data),
    .load_ready         (load_ready),
    .start              (start),
    .busy               (busy),
    .data_packet_ifmap  (data_packet_ifmap),
    .data_packet_filter (data_packet_filter),
    .gin_enable_ifmap   (gin_enable_ifmap),
    .gin_enable_filter  (gin_enable_filter),
    .pe_reset           (pe_reset),
    .ofmap_valid        (ofmap_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [BW-1:0]  m_filt [PY][FW];
  logic [BW-1:0]  m_ifm  [DIAG][FW];
  logic [PKT-1:0] q_ifm  [$];
  logic [PKT-1:0] q_filt [$];
  int             last_e = -100;
  int             n_checks = 0;
  int             n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < PY; r++) for (int p = 0; p < FW; p++) m_filt[r][p] = '0;
    for (int d = 0; d < DIAG; d++) for (int p = 0; p < FW; p++) m_ifm[d][p] = '0;
    q_ifm.delete();
    q_filt.delete();
    last_e = -100;
  endtask

  // Called #1 after a rising edge; drives one cycle of inputs that the next
  // edge samples, and applies the same request to the model.
  task automatic step(input logic st, input logic le, input logic sel,
                      input logic [7:0] a, input logic [BW-1:0] d);
    int f;
    int ai;
    bit idle;
    f    = cyc + 1;
    ai   = int'(a);
    idle = (f >= last_e + NEXT_OK);
    start     = st;
    load_en   = le;
    load_sel  = sel;
    load_addr = a;
    load_data = d;
    if (le && idle) begin
      if (!sel && ai < PY * FW) m_filt[ai / FW][ai % FW] = d;
      else if (sel && ai < DIAG * FW) m_ifm[ai / FW][ai % FW] = d;
    end
    if (st && idle) begin
      last_e = f;
      for (int p = 0; p < FW; p++) begin
        for (int k = 0; k < DIAG; k++) begin
          q_ifm.push_back({TL'(0), TL'(k), m_ifm[k][p]});
          if (k < PY) q_filt.push_back({TL'(0), TL'(p), m_filt[k][p]});
        end
      end
    end
    @(posedge clk);
    #1;
    start   = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: control timing from the model every cycle; packets popped from
  // the scoreboard whenever the DUT raises an enable.
  always @(negedge clk) begin
    int e;
    int i;
    logic in_job;
    logic ie;
    logic fe;
    logic [5:0] ex;
    logic [5:0] ac;
    if (!rst) begin
      e      = last_e;
      i      = cyc - e - FIRST;
      in_job = (cyc >= e) && (cyc <= e + DONE_OFS);
      ie     = (cyc >= e + FIRST) && (cyc <= e + LAST);
      fe     = ie && ((i % DIAG) < PY);
      ex = {in_job, !in_job, (cyc != e), ie, fe, (cyc == e + DONE_OFS)};
      ac = {busy, load_ready, pe_reset, gin_enable_ifmap, gin_enable_filter, ofmap_valid};
      chk("ctrl{busy,ldrdy,pe_rst,en_i,en_f,ofv}", 64'(ac), 64'(ex));
      if (gin_enable_ifmap === 1'b1) begin
        if (q_ifm.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL ifmap_pkt at cycle %0d: got %h expected no packet", cyc, data_packet_ifmap);
        end else begin
          chk("ifmap_pkt", 64'(data_packet_ifmap), 64'(q_ifm.pop_front()));
        end
      end else begin
        chk("ifmap_pkt_idle", 64'(data_packet_ifmap), 64'd0);
      end
      if (gin_enable_filter === 1'b1) begin
        if (q_filt.size() == 0) begin
          n_checks++;
          n_err++;
          $display("FAIL filter_pkt at cycle %0d: got %h expected no packet", cyc, data_packet_filter);
        end else begin
          chk("filter_pkt", 64'(data_packet_filter), 64'(q_filt.pop_front()));
        end
      end else begin
        chk("filter_pkt_idle", 64'(data_packet_filter), 64'd0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    load_en   = 1'b0;
    load_sel  = 1'b0;
    load_addr = '0;
    load_data = '0;
    model_reset();
    #2;
    chk("reset_ctrl", 64'({busy, load_ready, pe_reset, gin_enable_ifmap,
                           gin_enable_filter, ofmap_valid}), 64'(6'b011000));
    chk("reset_pkts", 64'({data_packet_ifmap, data_packet_filter}), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed tile: filter[r][p] = r+p, ifmap[d][p] = d+p.
    for (int r = 0; r < PY; r++)
      for (int p = 0; p < FW; p++) step(1'b0, 1'b1, 1'b0, 8'(r * FW + p), BW'(r + p));
    for (int d = 0; d < DIAG; d++)
      for (int p = 0; p < FW; p++) step(1'b0, 1'b1, 1'b1, 8'(d * FW + p), BW'(d + p));
    step(1'b1, 1'b0, 1'b0, 8'd0, '0);
    idle_cycles(NEXT_OK + 2);

    // Random loads including out-of-range addresses, then a job.
    step(1'b0, 1'b1, 1'b0, 8'd9, 16'hBEEF);
    step(1'b0, 1'b1, 1'b1, 8'd15, 16'hDEAD);
    for (int n = 0; n < 10; n++)
      step(1'b0, 1'b1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 20)), 16'($urandom));
    step(1'b1, 1'b0, 1'b0, 8'd0, '0);
    idle_cycles(NEXT_OK + 2);

    // start + load mid-STREAM are dropped; then load+start in the same idle cycle.
    step(1'b1, 1'b0, 1'b0, 8'd0, '0);
    idle_cycles(6);
    step(1'b1, 1'b1, 1'b1, 8'd0, 16'd99);
    idle_cycles(NEXT_OK);
    step(1'b1, 1'b1, 1'b1, 8'd0, 16'd99);
    idle_cycles(NEXT_OK + 2);

    // Asynchronous reset at stream beat 7.
    step(1'b1, 1'b0, 1'b0, 8'd0, '0);
    idle_cycles(FIRST + 7);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_ctrl", 64'({busy, load_ready, pe_reset, gin_enable_ifmap,
                             gin_enable_filter, ofmap_valid}), 64'(6'b011000));
    chk("rst_mid_pkts", 64'({data_packet_ifmap, data_packet_filter}), 64'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, 1'b0, 8'd0, '0);
    idle_cycles(NEXT_OK + 2);

    // Random traffic: loads and starts at arbitrary times, including while busy.
    for (int n = 0; n < 150; n++)
      step(($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom_range(0, 17)), 16'($urandom));
    idle_cycles(NEXT_OK + 2);

    chk("queues_drained", 64'(q_ifm.size() + q_filt.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
